// File: rtl/tcam_row_write_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tcam_row_write_decoder
// Description : Decodes write/invalidate requests into one-hot row selects and
//               sequences a registered key-then-mask write into the TCAM
//               array, keeping the per-row valid map for the match path.
//               Optional macro TCAM_AUTO_ALLOC_EN enables auto-allocation of
//               the lowest free row for writes with req_auto_i set.
// Revision    : 1.0 - initial release
// ============================================================================
module tcam_row_write_decoder #(
    parameter int ADDR_W = 4,
    parameter int ROWS   = 16,
    parameter int KEY_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_auto_i,
    input  logic [KEY_W-1:0]  req_key_i,
    input  logic [KEY_W-1:0]  req_mask_i,
    output logic [ROWS-1:0]   row_sel_o,
    output logic              row_we_key_o,
    output logic              row_we_mask_o,
    output logic [KEY_W-1:0]  wr_data_o,
    output logic [ROWS-1:0]   valid_map_o,
    output logic              full_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] resp_addr_o,
    output logic              resp_err_o
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_KEY  = 3'd1;
    localparam logic [2:0] ST_MASK = 3'd2;
    localparam logic [2:0] ST_INV  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [KEY_W-1:0]  mask_q, mask_d;
    logic              err_q, err_d;
    logic              req_ready_q, req_ready_d;
    logic [ROWS-1:0]   row_sel_q, row_sel_d;
    logic              we_key_q, we_key_d;
    logic              we_mask_q, we_mask_d;
    logic [KEY_W-1:0]  wr_data_q, wr_data_d;
    logic [ROWS-1:0]   valid_map_q, valid_map_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
    logic              resp_err_q, resp_err_d;

    logic              w_accept;
    logic              w_alloc_fail;
    logic [ADDR_W-1:0] w_tgt_addr;
    logic [ROWS-1:0]   w_dec;

    assign w_accept = req_valid_i && req_ready_q;

`ifdef TCAM_AUTO_ALLOC_EN
    logic              w_free_found;
    logic [ADDR_W-1:0] w_free_addr;

    // Scanning downwards leaves the lowest-index free row as the final winner.
    always_comb begin
        w_free_found = 1'b0;
        w_free_addr  = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!valid_map_q[i]) begin
                w_free_found = 1'b1;
                w_free_addr  = ADDR_W'(i);
            end
        end
    end

    assign w_alloc_fail = req_auto_i && !req_op_i && !w_free_found;
    assign w_tgt_addr   = (req_auto_i && !req_op_i) ? w_free_addr : req_addr_i;
`else
    logic w_unused_auto;
    assign w_unused_auto = req_auto_i;
    assign w_alloc_fail  = 1'b0;
    assign w_tgt_addr    = req_addr_i;
`endif

    always_comb begin
        addr_d = addr_q;
        mask_d = mask_q;
        err_d  = err_q;
        if (w_accept) begin
            addr_d = w_tgt_addr;
            mask_d = req_mask_i;
            err_d  = w_alloc_fail;
        end
    end

    // Row decode works on the next address so the select can be registered
    // alongside the state that uses it.
    for (genvar r = 0; r < ROWS; r++) begin : g_row_dec
        assign w_dec[r] = (addr_d == ADDR_W'(r));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (req_op_i) begin
                        state_d = ST_INV;
                    end else if (w_alloc_fail) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_KEY;
                    end
                end
            end
            ST_KEY:  state_d = ST_MASK;
            ST_MASK: state_d = ST_DONE;
            ST_INV:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        row_sel_d   = '0;
        we_key_d    = 1'b0;
        we_mask_d   = 1'b0;
        wr_data_d   = '0;
        req_ready_d = (state_d == ST_IDLE);
        done_d      = (state_d == ST_DONE);
        resp_addr_d = resp_addr_q;
        resp_err_d  = 1'b0;
        valid_map_d = valid_map_q;

        case (state_d)
            ST_KEY: begin
                row_sel_d = w_dec;
                we_key_d  = 1'b1;
                wr_data_d = req_key_i;
            end
            ST_MASK: begin
                row_sel_d = w_dec;
                we_mask_d = 1'b1;
                wr_data_d = mask_q;
            end
            ST_INV: begin
                row_sel_d = w_dec;
            end
            ST_DONE: begin
                resp_addr_d = addr_d;
                resp_err_d  = err_d;
            end
            default: begin
                row_sel_d = '0;
            end
        endcase

        // A row only becomes valid once its mask phase has completed.
        if (state_q == ST_MASK) begin
            valid_map_d[addr_q] = 1'b1;
        end else if (state_q == ST_INV) begin
            valid_map_d[addr_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            mask_q      <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            row_sel_q   <= '0;
            we_key_q    <= 1'b0;
            we_mask_q   <= 1'b0;
            wr_data_q   <= '0;
            valid_map_q <= '0;
            done_q      <= 1'b0;
            resp_addr_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            row_sel_q   <= row_sel_d;
            we_key_q    <= we_key_d;
            we_mask_q   <= we_mask_d;
            wr_data_q   <= wr_data_d;
            valid_map_q <= valid_map_d;
            done_q      <= done_d;
            resp_addr_q <= resp_addr_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign req_ready_o   = req_ready_q;
    assign row_sel_o     = row_sel_q;
    assign row_we_key_o  = we_key_q;
    assign row_we_mask_o = we_mask_q;
    assign wr_data_o     = wr_data_q;
    assign valid_map_o   = valid_map_q;
    assign full_o        = &valid_map_q;
    assign done_o        = done_q;
    assign resp_addr_o   = resp_addr_q;
    assign resp_err_o    = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tcam_row_write_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tcam_row_write_decoder
// Description : Self-checking bench: vector table plus scoreboarded sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcam_row_write_decoder;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_op    = 1'b0;
    logic        req_auto  = 1'b0;
    logic [3:0]  req_addr  = '0;
    logic [7:0]  req_key   = '0;
    logic [7:0]  req_mask  = '0;
    logic        req_ready;
    logic [15:0] row_sel;
    logic        row_we_key;
    logic        row_we_mask;
    logic [7:0]  wr_data;
    logic [15:0] valid_map;
    logic        full;
    logic        done;
    logic [3:0]  resp_addr;
    logic        resp_err;

    tcam_row_write_decoder #(.ADDR_W(4), .ROWS(16), .KEY_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_addr_i    (req_addr),
        .req_auto_i    (req_auto),
        .req_key_i     (req_key),
        .req_mask_i    (req_mask),
        .row_sel_o     (row_sel),
        .row_we_key_o  (row_we_key),
        .row_we_mask_o (row_we_mask),
        .wr_data_o     (wr_data),
        .valid_map_o   (valid_map),
        .full_o        (full),
        .done_o        (done),
        .resp_addr_o   (resp_addr),
        .resp_err_o    (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          op;
        logic [3:0]  addr;
        logic [7:0]  key;
        logic [7:0]  mask;
        logic [3:0]  exp_addr;
        logic [15:0] exp_vm;
    } vec_t;

    typedef struct {
        bit          op;
        logic [3:0]  addr;
        logic [7:0]  key;
        logic [7:0]  mask;
        bit          err;
        logic [15:0] vm;
        int          lat;
        int          acc;
    } exp_t;

    vec_t        vecs[8];
    exp_t        sb[$];
    int          cyc      = 0;
    int          n_pass   = 0;
    int          n_total  = 0;
    int          last_acc = 0;
    logic [15:0] model_vm = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard monitor: checks every phase of the outstanding request.
    always @(negedge clk) begin : mon
        exp_t it;
        if (rst_n) begin
            chk("onehot_sel", 32'($countones(row_sel) <= 1), 32'd1);
            chk("strobe_excl", 32'(row_we_key && row_we_mask), 32'd0);
            if (sb.size() == 0) begin
                chk("idle_quiet", 32'({row_sel, row_we_key, row_we_mask, done}), 32'd0);
            end else begin
                if (row_we_key) begin
                    chk("key_phase", 32'({sb[0].op, sb[0].err}), 32'd0);
                    chk("key_lat", 32'(cyc - sb[0].acc), 32'd1);
                    chk("key_row", 32'(row_sel), 32'(16'h1 << sb[0].addr));
                    chk("key_data", 32'(wr_data), 32'(sb[0].key));
                end
                if (row_we_mask) begin
                    chk("mask_phase", 32'({sb[0].op, sb[0].err}), 32'd0);
                    chk("mask_lat", 32'(cyc - sb[0].acc), 32'd2);
                    chk("mask_row", 32'(row_sel), 32'(16'h1 << sb[0].addr));
                    chk("mask_data", 32'(wr_data), 32'(sb[0].mask));
                end
                if (row_sel != 16'h0 && !row_we_key && !row_we_mask) begin
                    chk("inv_op", 32'(sb[0].op), 32'd1);
                    chk("inv_lat", 32'(cyc - sb[0].acc), 32'd1);
                    chk("inv_row", 32'(row_sel), 32'(16'h1 << sb[0].addr));
                end
                if (done) begin
                    it = sb.pop_front();
                    chk("done_lat", 32'(cyc - it.acc), 32'(it.lat));
                    chk("resp_addr", 32'(resp_addr), 32'(it.addr));
                    chk("resp_err", 32'(resp_err), 32'(it.err));
                    chk("valid_map", 32'(valid_map), 32'(it.vm));
                    chk("full", 32'(full), 32'(&it.vm));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge with
    // req_valid still high, so consecutive calls keep the request asserted.
    task automatic send(input bit op, input logic [3:0] addr, input bit au,
                        input logic [7:0] key, input logic [7:0] mask,
                        input logic [3:0] exp_addr, input bit exp_err,
                        input logic [15:0] exp_vm);
        exp_t it;
        int   n;
        req_op    = op;
        req_addr  = addr;
        req_auto  = au;
        req_key   = key;
        req_mask  = mask;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        it.op   = op;
        it.addr = exp_addr;
        it.key  = key;
        it.mask = mask;
        it.err  = exp_err;
        it.vm   = exp_vm;
        it.lat  = op ? 2 : (exp_err ? 1 : 3);
        it.acc  = cyc;
        sb.push_back(it);
        last_acc = cyc;
        model_vm = exp_vm;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic wr(input int a);
        send(1'b0, 4'(a), 1'b0, 8'(a * 16 + 1), 8'(~a), 4'(a), 1'b0, model_vm | (16'h1 << a));
        req_valid = 1'b0;
        drain();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        model_vm = '0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a0;
        vecs[0] = '{1'b0, 4'd5,  8'hA5, 8'h0F, 4'd5,  16'h0020};
        vecs[1] = '{1'b1, 4'd5,  8'h00, 8'h00, 4'd5,  16'h0000};
        vecs[2] = '{1'b1, 4'd5,  8'h00, 8'h00, 4'd5,  16'h0000};
        vecs[3] = '{1'b0, 4'd0,  8'h3C, 8'hF0, 4'd0,  16'h0001};
        vecs[4] = '{1'b0, 4'd0,  8'h55, 8'h00, 4'd0,  16'h0001};
        vecs[5] = '{1'b0, 4'd15, 8'hFF, 8'h81, 4'd15, 16'h8001};
        vecs[6] = '{1'b0, 4'd9,  8'h12, 8'h34, 4'd9,  16'h8201};
        vecs[7] = '{1'b1, 4'd0,  8'h00, 8'h00, 4'd0,  16'h8200};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_row_sel", 32'(row_sel), 32'd0);
        chk("rst_strobes", 32'({row_we_key, row_we_mask}), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_valid_map", 32'(valid_map), 32'd0);
        chk("rst_resp", 32'({done, resp_addr, resp_err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(req_ready), 32'd1);
        chk("rel_full", 32'(full), 32'd0);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].op, vecs[i].addr, 1'b0, vecs[i].key, vecs[i].mask,
                 vecs[i].exp_addr, 1'b0, vecs[i].exp_vm);
            req_valid = 1'b0;
            drain();
        end

`ifdef TCAM_AUTO_ALLOC_EN
        send(1'b0, 4'd3, 1'b1, 8'h66, 8'h99, 4'd0, 1'b0, model_vm | 16'h0001);
`else
        send(1'b0, 4'd3, 1'b1, 8'h66, 8'h99, 4'd3, 1'b0, model_vm | 16'h0008);
`endif
        req_valid = 1'b0;
        drain();

        // Reset asserted during the mask phase of a write to row 3.
        send(1'b0, 4'd3, 1'b0, 8'h77, 8'h88, 4'd3, 1'b0, model_vm | 16'h0008);
        req_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_row_sel", 32'(row_sel), 32'd0);
        chk("mid_rst_strobes", 32'({row_we_key, row_we_mask}), 32'd0);
        chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
        chk("mid_rst_valid_map", 32'(valid_map), 32'd0);
        chk("mid_rst_resp", 32'({done, resp_addr, resp_err}), 32'd0);
        sb.delete();
        model_vm = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_vm_after", 32'(valid_map), 32'd0);

        // Back-to-back writes with req_valid held high.
        send(1'b0, 4'd0, 1'b0, 8'h11, 8'h22, 4'd0, 1'b0, model_vm | 16'h0001);
        a0 = last_acc;
        send(1'b0, 4'd15, 1'b0, 8'h33, 8'h44, 4'd15, 1'b0, model_vm | 16'h8000);
        chk("b2b_gap", 32'(last_acc - a0), 32'd4);
        req_valid = 1'b0;
        drain();
        chk("b2b_vm", 32'(valid_map), 32'h8001);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr(i);
            if (i == 14) chk("full_at_15", 32'(full), 32'd0);
        end
        chk("full_at_16", 32'(full), 32'd1);
        chk("vm_all", 32'(valid_map), 32'hFFFF);

`ifdef TCAM_AUTO_ALLOC_EN
        send(1'b0, 4'd9, 1'b1, 8'hAA, 8'hBB, 4'd0, 1'b1, 16'hFFFF);
        req_valid = 1'b0;
        drain();

        do_reset();
        wr(0);
        wr(1);
        wr(2);
        send(1'b0, 4'd12, 1'b1, 8'hC3, 8'h3C, 4'd3, 1'b0, 16'h000F);
        req_valid = 1'b0;
        drain();
        chk("auto_vm", 32'(valid_map), 32'h000F);
        send(1'b1, 4'd1, 1'b1, 8'h00, 8'h00, 4'd1, 1'b0, 16'h000D);
        req_valid = 1'b0;
        drain();
        chk("auto_inv_vm", 32'(valid_map), 32'h000D);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
